// File: rtl/multi_radix_mul_arbiter_pkg.sv
// Shared definitions for the multi-requester multiplier arbiter.
// Holds the control FSM state type and the default operand/product widths
// and multiplier latency used by the top module and the multiply pipeline.
package multi_radix_mul_arbiter_pkg;

    // Default geometry: signed A operand, unsigned B operand, truncated product
    localparam int DEFAULT_A_W = 15;
    localparam int DEFAULT_B_W = 14;
    localparam int DEFAULT_P_W = 15;
    localparam int DEFAULT_LAT = 3;

    // RUN accepts work, DRAIN waits for the pipeline to empty, DONE pulses flush_done
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/multi_radix_mul_pipe.sv
// Clock-enabled multiply pipeline: operand register, product register and
// LAT-2 output registers (a single output register at the default LAT=3).
// The product is the low P_W bits of signed a times zero-extended b.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   ce_i       : advance enable; every register holds while low
//   a_i        : signed multiplicand
//   b_i        : unsigned multiplier
//   p_o        : truncated product from the final register
module multi_radix_mul_pipe
    import multi_radix_mul_arbiter_pkg::*;
#(
    parameter int A_W = DEFAULT_A_W,
    parameter int B_W = DEFAULT_B_W,
    parameter int P_W = DEFAULT_P_W,
    parameter int LAT = DEFAULT_LAT
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           ce_i,
    input  logic [A_W-1:0] a_i,
    input  logic [B_W-1:0] b_i,
    output logic [P_W-1:0] p_o
);

    // One extra bit holds the zero-extended multiplier as a positive signed value
    localparam int FULL_W = A_W + B_W + 1;

    logic [A_W-1:0]           opA_q;
    logic [B_W-1:0]           opB_q;
    logic [P_W-1:0]           prod_q;
    logic [P_W-1:0]           prod_d;
    logic [P_W-1:0]           outStage_q [LAT-2];
    logic signed [FULL_W-1:0] aExt;
    logic signed [FULL_W-1:0] bExt;

    // Sign-extend A, zero-extend B, keep only the low P_W bits of the product
    always_comb begin
        aExt   = FULL_W'($signed(opA_q));
        bExt   = FULL_W'({1'b0, opB_q});
        prod_d = P_W'(aExt * bExt);
    end

    // All stages move together under ce so results keep their tag alignment
    always_ff @(posedge clk) begin
        if (reset) begin
            opA_q  <= '0;
            opB_q  <= '0;
            prod_q <= '0;
            for (int i = 0; i < LAT - 2; i++) begin
                outStage_q[i] <= '0;
            end
        end else if (ce_i) begin
            opA_q         <= a_i;
            opB_q         <= b_i;
            prod_q        <= prod_d;
            outStage_q[0] <= prod_q;
            for (int i = 1; i < LAT - 2; i++) begin
                outStage_q[i] <= outStage_q[i-1];
            end
        end
    end

    assign p_o = outStage_q[LAT-3];

endmodule

// File: rtl/multi_radix_mul_arbiter.sv
// Round-robin arbiter in front of a shared signed x unsigned multiplier.
// Each accepted operation carries its requester index through a valid/tag
// pipeline so the result is routed back one-hot on rsp_valid. A result that
// its requester will not take freezes the whole pipeline. flush_req drains
// the pipeline and reports completion with a one-cycle flush_done pulse.
// Optional statistics (stat_grants, stat_stall) exist only when the macro
// MULTI_RADIX_MUL_ARB_STATS_EN is defined.
// Ports:
//   clk, reset            : clock and synchronous active-high reset
//   req_valid/req_ready   : per-requester operand handshake
//   req_a, req_b          : packed per-requester operands
//   rsp_valid/rsp_ready   : one-hot result valid, per-requester accept
//   rsp_p                 : shared result bus
//   flush_req/flush_done  : drain request and completion pulse
//   busy                  : any operation in flight
module multi_radix_mul_arbiter
    import multi_radix_mul_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int A_W     = DEFAULT_A_W,
    parameter int B_W     = DEFAULT_B_W,
    parameter int P_W     = DEFAULT_P_W,
    parameter int LAT     = DEFAULT_LAT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*A_W-1:0] req_a,
    input  logic [NUM_REQ*B_W-1:0] req_b,
    output logic [NUM_REQ-1:0]     rsp_valid,
    input  logic [NUM_REQ-1:0]     rsp_ready,
    output logic [P_W-1:0]         rsp_p,
    input  logic                   flush_req,
    output logic                   flush_done,
    output logic                   busy
`ifdef MULTI_RADIX_MUL_ARB_STATS_EN
    ,
    output logic [NUM_REQ*32-1:0]  stat_grants,
    output logic [31:0]            stat_stall
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_e       state_q;
    logic [IDX_W-1:0] rrPtr_q;
    logic             flushDone_q;
    logic [LAT-1:0]   pipeValid_q;
    logic [IDX_W-1:0] pipeTag_q [LAT];

    logic             ce;
    logic             grantFound;
    logic             grantEn;
    logic [IDX_W-1:0] grantIdx;
    logic [IDX_W-1:0] candIdx;
    logic [A_W-1:0]   selA;
    logic [B_W-1:0]   selB;
    logic             outValid;
    logic [IDX_W-1:0] outTag;

    assign outValid = pipeValid_q[LAT-1];
    assign outTag   = pipeTag_q[LAT-1];

    // Freeze everything while the output holds a result its owner refuses
    assign ce = !(outValid && !rsp_ready[outTag]);

    // Search starts one past the last accepted index and wraps once around
    always_comb begin
        grantFound = 1'b0;
        grantIdx   = '0;
        candIdx    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            candIdx = IDX_W'((int'(rrPtr_q) + k) % NUM_REQ);
            if (!grantFound && req_valid[candIdx]) begin
                grantFound = 1'b1;
                grantIdx   = candIdx;
            end
        end
    end

    assign grantEn   = grantFound && (state_q == RUN) && ce;
    assign req_ready = grantEn ? (NUM_REQ'(1) << grantIdx) : '0;
    assign selA      = req_a[grantIdx*A_W +: A_W];
    assign selB      = req_b[grantIdx*B_W +: B_W];

    // Valid/tag shadow of the multiply pipeline, advancing only with ce
    always_ff @(posedge clk) begin
        if (reset) begin
            pipeValid_q <= '0;
            for (int i = 0; i < LAT; i++) begin
                pipeTag_q[i] <= '0;
            end
        end else if (ce) begin
            pipeValid_q  <= {pipeValid_q[LAT-2:0], grantEn};
            pipeTag_q[0] <= grantIdx;
            for (int i = 1; i < LAT; i++) begin
                pipeTag_q[i] <= pipeTag_q[i-1];
            end
        end
    end

    // Control FSM with round-robin pointer and registered flush_done.
    // DRAIN looks at the valid bits, so an op accepted alongside flush_req
    // is already in the pipeline when DRAIN first evaluates emptiness.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            rrPtr_q     <= IDX_W'(NUM_REQ - 1);
            flushDone_q <= 1'b0;
        end else begin
            if (grantEn) begin
                rrPtr_q <= grantIdx;
            end
            case (state_q)
                RUN: begin
                    flushDone_q <= 1'b0;
                    if (flush_req) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pipeValid_q == '0) begin
                        state_q     <= DONE;
                        flushDone_q <= 1'b1;
                    end
                end
                DONE: begin
                    state_q     <= RUN;
                    flushDone_q <= 1'b0;
                end
                default: begin
                    state_q     <= RUN;
                    flushDone_q <= 1'b0;
                end
            endcase
        end
    end

    multi_radix_mul_pipe #(
        .A_W (A_W),
        .B_W (B_W),
        .P_W (P_W),
        .LAT (LAT)
    ) u_pipe (
        .clk   (clk),
        .reset (reset),
        .ce_i  (ce),
        .a_i   (selA),
        .b_i   (selB),
        .p_o   (rsp_p)
    );

    assign rsp_valid  = outValid ? (NUM_REQ'(1) << outTag) : '0;
    assign flush_done = flushDone_q;
    assign busy       = |pipeValid_q;

`ifdef MULTI_RADIX_MUL_ARB_STATS_EN
    logic [NUM_REQ*32-1:0] statGrants_q;
    logic [31:0]           statStall_q;

    // Free-running wrap-around counters of transfers per requester and stalls
    always_ff @(posedge clk) begin
        if (reset) begin
            statGrants_q <= '0;
            statStall_q  <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grantEn && (grantIdx == IDX_W'(i))) begin
                    statGrants_q[i*32 +: 32] <= statGrants_q[i*32 +: 32] + 32'd1;
                end
            end
            if (!ce) begin
                statStall_q <= statStall_q + 32'd1;
            end
        end
    end

    assign stat_grants = statGrants_q;
    assign stat_stall  = statStall_q;
`endif

endmodule
